// File: rtl/ssi_biss_slave_pkg.sv
// Shared encodings for the SSI / BiSS-C encoder-emulator slave: link modes,
// frame states and the CRC-6 generator polynomial.
package ssi_biss_slave_pkg;

  localparam logic [1:0] SLV_MODE_DISABLED = 2'd0;
  localparam logic [1:0] SLV_MODE_SSI      = 2'd1;
  localparam logic [1:0] SLV_MODE_BISS     = 2'd2;

  // x^6 + x + 1 with the x^6 term implicit (0x43 in full form)
  localparam logic [5:0] CRC6_POLY = 6'h03;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    START,
    CDS,
    DATA,
    STATUS,
    CRC,
    TIMEOUT
  } slv_state_t;

  function automatic logic mode_active(input logic [1:0] mode);
    return (mode == SLV_MODE_SSI) || (mode == SLV_MODE_BISS);
  endfunction

endpackage

// File: rtl/ssi_biss_slave_if.sv
// Control, status and serial-link signals of the encoder-emulator slave.
interface ssi_biss_slave_if #(
  parameter int POS_W = 32
) ();

  logic             enable;
  logic [1:0]       mode_sel;
  logic             gray_en;
  logic [POS_W-1:0] position_in;
  logic             err_n;
  logic             warn_n;
  logic             ma_in;
  logic             slo_out;
  logic             slo_oe;
  logic             busy;
  logic             frame_done;
  logic             frame_abort;

  modport slave (
    input  enable, mode_sel, gray_en, position_in, err_n, warn_n, ma_in,
    output slo_out, slo_oe, busy, frame_done, frame_abort
  );

  modport master (
    output enable, mode_sel, gray_en, position_in, err_n, warn_n, ma_in,
    input  slo_out, slo_oe, busy, frame_done, frame_abort
  );

endinterface

// File: rtl/ssi_biss_slave_crc6.sv
// Serial BiSS CRC-6 (x^6+x+1, init 0), one bit per shift_en, MSB-first data.
// Kept standalone so a link master can reuse it for checking.
module biss_crc6
  import ssi_biss_slave_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       din,
  output logic [5:0] crc
);

  logic [5:0] crc_reg;
  logic       feedback;

  assign feedback = din ^ crc_reg[5];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc_reg <= '0;
    end else if (clear) begin
      crc_reg <= '0;
    end else if (shift_en) begin
      crc_reg <= {crc_reg[4:0], 1'b0} ^ ({6{feedback}} & CRC6_POLY);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/ssi_biss_slave.sv
// Encoder-emulator slave: answers MA clock falls with an SSI or BiSS-C frame
// built from a position word latched at the first fall of the frame.
module ssi_biss_slave
  import ssi_biss_slave_pkg::*;
#(
  parameter int SSI_BITS       = 20,
  parameter int BISS_BITS      = 32,
  parameter int ACK_BITS       = 1,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int POS_W          = 32
) (
  input  logic clk,
  input  logic resetn,
  ssi_biss_slave_if.slave bus
);

  localparam int DW    = (SSI_BITS > BISS_BITS) ? SSI_BITS : BISS_BITS;
  localparam int CNT_W = $clog2(DW + 9);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] SSI_LAST  = CNT_W'(SSI_BITS - 1);
  localparam logic [CNT_W-1:0] BISS_LAST = CNT_W'(BISS_BITS - 1);
  localparam logic [CNT_W-1:0] ACK_LEN   = CNT_W'(ACK_BITS);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(5);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  slv_state_t       state_reg, state_next;
  logic [1:0]       mode_reg, mode_next;
  logic [DW-1:0]    data_reg, data_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic             slo_reg, slo_next;
  logic             oe_reg;
  logic             done_reg, done_next;
  logic             abort_reg, abort_next;
  logic             nerr_reg, nerr_next;
  logic             nwarn_reg, nwarn_next;

  logic [2:0]          ma_sync_reg;
  logic                ma_s, ma_fall, oe_cond;
  logic [SSI_BITS-1:0] ssi_bin, ssi_word;
  logic [4:0]          crc_inv;
  logic [DW-1:0]       ssi_just, biss_just, crc_just;
  logic [5:0]          crc_val;
  logic                crc_clear, crc_shift, crc_din;

  // [0],[1]: synchronizer; [2]: history for fall detect. Resets high because MA idles high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ma_sync_reg <= 3'b111;
    end else begin
      ma_sync_reg <= {ma_sync_reg[1:0], bus.ma_in};
    end
  end

  assign ma_s    = ma_sync_reg[1];
  assign ma_fall = ma_sync_reg[2] & ~ma_sync_reg[1];
  assign oe_cond = bus.enable && mode_active(bus.mode_sel);

  // Payloads are left-justified so both modes shift out of data_reg[DW-1]
  assign ssi_bin   = bus.position_in[SSI_BITS-1:0];
  assign ssi_word  = bus.gray_en ? (ssi_bin ^ (ssi_bin >> 1)) : ssi_bin;
  assign ssi_just  = DW'(ssi_word) << (DW - SSI_BITS);
  assign biss_just = DW'(bus.position_in[BISS_BITS-1:0]) << (DW - BISS_BITS);
  assign crc_inv   = ~crc_val[4:0];
  assign crc_just  = DW'(crc_inv) << (DW - 5);

  biss_crc6 u_crc (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .din      (crc_din),
    .crc      (crc_val)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      mode_reg    <= SLV_MODE_DISABLED;
      data_reg    <= '0;
      bit_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      slo_reg     <= 1'b1;
      oe_reg      <= 1'b0;
      done_reg    <= 1'b0;
      abort_reg   <= 1'b0;
      nerr_reg    <= 1'b1;
      nwarn_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      data_reg    <= data_next;
      bit_cnt_reg <= bit_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      slo_reg     <= slo_next;
      oe_reg      <= oe_cond;
      done_reg    <= done_next;
      abort_reg   <= abort_next;
      nerr_reg    <= nerr_next;
      nwarn_reg   <= nwarn_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    data_next    = data_reg;
    bit_cnt_next = bit_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    slo_next     = slo_reg;
    done_next    = 1'b0;
    abort_next   = 1'b0;
    nerr_next    = nerr_reg;
    nwarn_next   = nwarn_reg;
    crc_clear    = 1'b0;
    crc_shift    = 1'b0;
    crc_din      = 1'b0;

    if (state_reg == IDLE || !ma_s) begin
      to_cnt_next = '0;
    end else if (to_cnt_reg != TO_MAX) begin
      to_cnt_next = to_cnt_reg + TO_W'(1);
    end

    if (!oe_cond) begin
      state_next   = IDLE;
      slo_next     = 1'b1;
      bit_cnt_next = '0;
      to_cnt_next  = '0;
    end else if (state_reg != IDLE && bus.mode_sel != mode_reg) begin
      abort_next   = 1'b1;
      state_next   = IDLE;
      slo_next     = 1'b1;
      bit_cnt_next = '0;
      to_cnt_next  = '0;
    end else if (state_reg != IDLE && to_cnt_reg == TO_MAX) begin
      // A long MA-high ends a finished frame normally, anything earlier is a truncation
      done_next    = (state_reg == TIMEOUT);
      abort_next   = (state_reg != TIMEOUT);
      state_next   = IDLE;
      slo_next     = 1'b1;
      bit_cnt_next = '0;
      to_cnt_next  = '0;
    end else if (ma_fall) begin
      case (state_reg)
        IDLE: begin
          mode_next    = bus.mode_sel;
          bit_cnt_next = '0;
          crc_clear    = 1'b1;
          if (bus.mode_sel == SLV_MODE_SSI) begin
            data_next  = ssi_just << 1;
            slo_next   = ssi_just[DW-1];
            state_next = DATA;
          end else begin
            data_next  = biss_just;
            nerr_next  = bus.err_n;
            nwarn_next = bus.warn_n;
            slo_next   = 1'b1;
            state_next = ACK;
          end
        end
        ACK: begin
          if (bit_cnt_reg == ACK_LEN) begin
            slo_next     = 1'b1;
            bit_cnt_next = '0;
            state_next   = START;
          end else begin
            slo_next     = 1'b0;
            bit_cnt_next = bit_cnt_reg + CNT_ONE;
          end
        end
        START: begin
          slo_next   = 1'b0;
          state_next = CDS;
        end
        CDS: begin
          slo_next     = data_reg[DW-1];
          data_next    = data_reg << 1;
          crc_shift    = 1'b1;
          crc_din      = data_reg[DW-1];
          bit_cnt_next = '0;
          state_next   = DATA;
        end
        DATA: begin
          if (mode_reg == SLV_MODE_SSI && bit_cnt_reg == SSI_LAST) begin
            slo_next   = 1'b0;
            state_next = TIMEOUT;
          end else if (mode_reg == SLV_MODE_BISS && bit_cnt_reg == BISS_LAST) begin
            slo_next     = nerr_reg;
            crc_shift    = 1'b1;
            crc_din      = nerr_reg;
            bit_cnt_next = '0;
            state_next   = STATUS;
          end else begin
            slo_next     = data_reg[DW-1];
            data_next    = data_reg << 1;
            crc_shift    = (mode_reg == SLV_MODE_BISS);
            crc_din      = data_reg[DW-1];
            bit_cnt_next = bit_cnt_reg + CNT_ONE;
          end
        end
        STATUS: begin
          if (bit_cnt_reg == '0) begin
            slo_next     = nwarn_reg;
            crc_shift    = 1'b1;
            crc_din      = nwarn_reg;
            bit_cnt_next = CNT_ONE;
          end else begin
            // nW has been absorbed by now, so the CRC register is final
            slo_next     = ~crc_val[5];
            data_next    = crc_just;
            bit_cnt_next = '0;
            state_next   = CRC;
          end
        end
        CRC: begin
          if (bit_cnt_reg == CRC_LAST) begin
            slo_next   = 1'b0;
            state_next = TIMEOUT;
          end else begin
            slo_next     = data_reg[DW-1];
            data_next    = data_reg << 1;
            bit_cnt_next = bit_cnt_reg + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.slo_out     = slo_reg;
  assign bus.slo_oe      = oe_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.frame_done  = done_reg;
  assign bus.frame_abort = abort_reg;

endmodule

// File: tb/tb_ssi_biss_slave.sv
// Self-checking bench for ssi_biss_slave: bit streams sampled on MA rises are
// compared with a frame model built from the link rules.
`timescale 1ns/1ps
module tb_ssi_biss_slave;
  import ssi_biss_slave_pkg::*;

  localparam int TO   = 40;
  localparam int HP   = 8;
  localparam int ACKB = 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ssi_biss_slave_if #(.POS_W(32)) bus ();

  ssi_biss_slave #(
    .SSI_BITS(20), .BISS_BITS(32), .ACK_BITS(ACKB), .TIMEOUT_CYCLES(TO), .POS_W(32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.frame_abort === 1'b1) abort_cnt++;
  end

  typedef struct {
    logic [1:0]  mode;
    logic        gray;
    logic [31:0] pos;
    logic        e;
    logic        w;
    logic [31:0] exp_word;
    logic [1:0]  exp_stat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Remainder of msg*x^6 divided by x^6+x+1, by long division
  function automatic logic [5:0] crc6_model(input logic [33:0] msg);
    logic [39:0] m;
    logic [39:0] poly;
    m = {msg, 6'b0};
    for (int i = 39; i >= 6; i--) begin
      poly = 40'h43 << (i - 6);
      if (m[i]) m = m ^ poly;
    end
    return m[5:0];
  endfunction

  function automatic void model(input logic [1:0] mode, input logic gray, input logic [31:0] pos,
                                input logic e, input logic w, output logic [63:0] bits, output int n);
    logic [19:0] sw;
    logic [5:0]  crc;
    bits = '0;
    n = 0;
    if (mode == SLV_MODE_SSI) begin
      sw = pos[19:0];
      if (gray) sw = sw ^ (sw >> 1);
      for (int i = 19; i >= 0; i--) begin bits = {bits[62:0], sw[i]}; n++; end
      bits = {bits[62:0], 1'b0}; n++;
    end else if (mode == SLV_MODE_BISS) begin
      crc = ~crc6_model({pos, e, w});
      bits = {bits[62:0], 1'b1}; n++;
      for (int i = 0; i < ACKB; i++) begin bits = {bits[62:0], 1'b0}; n++; end
      bits = {bits[62:0], 1'b1}; n++;
      bits = {bits[62:0], 1'b0}; n++;
      for (int i = 31; i >= 0; i--) begin bits = {bits[62:0], pos[i]}; n++; end
      bits = {bits[62:0], e}; n++;
      bits = {bits[62:0], w}; n++;
      for (int i = 5; i >= 0; i--) begin bits = {bits[62:0], crc[i]}; n++; end
      bits = {bits[62:0], 1'b0}; n++;
    end else begin
      for (int i = 0; i < 21; i++) begin bits = {bits[62:0], 1'b1}; n++; end
    end
  endfunction

  task automatic pulse(output logic b);
    bus.ma_in = 1'b0;
    repeat (HP) @(negedge clk);
    b = bus.slo_out;
    bus.ma_in = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  // Inputs are scrambled mid-frame; the frame must keep its latched values
  task automatic run_pulses(input int n, output logic [63:0] cap, output logic oe_seen);
    logic b;
    cap = '0;
    oe_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      pulse(b);
      cap = {cap[62:0], b};
      if (i == 0) oe_seen = bus.slo_oe;
      if (i == 3) begin
        bus.position_in = 32'hFFFF_FFFF;
        bus.err_n = ~bus.err_n;
        bus.warn_n = ~bus.warn_n;
      end
    end
  endtask

  task automatic settle(output int rise_at);
    rise_at = -1;
    for (int c = 1; c <= TO + 20; c++) begin
      @(negedge clk);
      if (rise_at < 0 && bus.slo_out === 1'b1) rise_at = c;
    end
  endtask

  task automatic do_frame(input logic [1:0] mode, input logic gray, input logic [31:0] pos,
                          input logic e, input logic w, output logic [63:0] cap);
    logic [63:0] exp_bits;
    int n, d0, a0, rise_at;
    logic oe_seen, active;
    active = (mode == SLV_MODE_SSI) || (mode == SLV_MODE_BISS);
    model(mode, gray, pos, e, w, exp_bits, n);
    bus.mode_sel = mode;
    bus.gray_en = gray;
    bus.position_in = pos;
    bus.err_n = e;
    bus.warn_n = w;
    @(negedge clk);
    @(negedge clk);
    d0 = done_cnt;
    a0 = abort_cnt;
    run_pulses(n, cap, oe_seen);
    settle(rise_at);
    $display("frame mode=%0d gray=%0d pos=%h nE=%0d nW=%0d pulses=%0d stream=%0h",
             mode, gray, pos, e, w, n, cap);
    check("stream", cap, exp_bits);
    check("slo_oe", 64'(oe_seen), 64'(active));
    check("done_pulses", 64'(done_cnt - d0), active ? 64'd1 : 64'd0);
    check("abort_pulses", 64'(abort_cnt - a0), 64'd0);
    check("busy_after", 64'(bus.busy), 64'd0);
    check("slo_idle", 64'(bus.slo_out), 64'd1);
    if (active) begin
      n_cmp++;
      if (rise_at < 0 || rise_at + HP < TO || rise_at + HP > TO + 4) begin
        n_bad++;
        $display("FAIL slo_release: got %0d clk after MA idle, expected %0d..%0d", rise_at + HP, TO, TO + 4);
      end
    end
  endtask

  initial begin
    logic [63:0] cap;
    logic        oe_seen;
    logic [31:0] word;
    int          d0, a0, rise_at;

    vecs[0] = '{SLV_MODE_SSI,  1'b0, 32'h000A5A5A, 1'b1, 1'b1, 32'h000A5A5A, 2'b00};
    vecs[1] = '{SLV_MODE_SSI,  1'b1, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 2'b00};
    vecs[2] = '{SLV_MODE_BISS, 1'b0, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 2'b10};
    vecs[3] = '{SLV_MODE_BISS, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 2'b01};
    vecs[4] = '{SLV_MODE_SSI,  1'b1, 32'hABC80000, 1'b0, 1'b0, 32'h000C0000, 2'b00};
    vecs[5] = '{2'd3,          1'b0, 32'h00000000, 1'b1, 1'b1, 32'h000FFFFF, 2'b00};
    vecs[6] = '{SLV_MODE_BISS, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF, 2'b00};

    resetn = 1'b0;
    bus.enable = 1'b1;
    bus.mode_sel = SLV_MODE_SSI;
    bus.gray_en = 1'b0;
    bus.position_in = '0;
    bus.err_n = 1'b1;
    bus.warn_n = 1'b1;
    bus.ma_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_slo_out", 64'(bus.slo_out), 64'd1);
    check("rst_slo_oe", 64'(bus.slo_oe), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.frame_done), 64'd0);
    check("rst_abort", 64'(bus.frame_abort), 64'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_frame(vecs[i].mode, vecs[i].gray, vecs[i].pos, vecs[i].e, vecs[i].w, cap);
      word = (vecs[i].mode == SLV_MODE_BISS) ? 32'(cap >> 9) : 32'((cap >> 1) & 64'hFFFFF);
      check("payload", 64'(word), 64'(vecs[i].exp_word));
      if (vecs[i].mode == SLV_MODE_BISS) check("status", (cap >> 7) & 64'h3, 64'(vecs[i].exp_stat));
    end

    for (int i = 0; i < 10; i++) begin
      do_frame(2'($urandom_range(1, 2)), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), cap);
    end

    // BiSS frame truncated after 10 bits
    bus.mode_sel = SLV_MODE_BISS;
    bus.position_in = $urandom;
    @(negedge clk);
    @(negedge clk);
    d0 = done_cnt;
    a0 = abort_cnt;
    run_pulses(10, cap, oe_seen);
    $display("truncated BiSS frame after 10 pulses");
    check("busy_midframe", 64'(bus.busy), 64'd1);
    settle(rise_at);
    check("trunc_abort", 64'(abort_cnt - a0), 64'd1);
    check("trunc_done", 64'(done_cnt - d0), 64'd0);
    check("trunc_slo", 64'(bus.slo_out), 64'd1);
    check("trunc_busy", 64'(bus.busy), 64'd0);
    do_frame(SLV_MODE_BISS, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, cap);

    // enable dropped mid-frame
    bus.mode_sel = SLV_MODE_SSI;
    @(negedge clk);
    @(negedge clk);
    d0 = done_cnt;
    a0 = abort_cnt;
    run_pulses(5, cap, oe_seen);
    check("en_busy_before", 64'(bus.busy), 64'd1);
    bus.enable = 1'b0;
    @(negedge clk);
    $display("enable dropped mid-frame");
    check("en_slo_oe", 64'(bus.slo_oe), 64'd0);
    check("en_busy", 64'(bus.busy), 64'd0);
    check("en_slo_out", 64'(bus.slo_out), 64'd1);
    repeat (TO + 10) @(negedge clk);
    check("en_no_abort", 64'(abort_cnt - a0), 64'd0);
    check("en_no_done", 64'(done_cnt - d0), 64'd0);
    bus.enable = 1'b1;
    do_frame(SLV_MODE_SSI, 1'b0, 32'h00012345, 1'b1, 1'b1, cap);

    // mode switched while busy
    a0 = abort_cnt;
    run_pulses(5, cap, oe_seen);
    bus.mode_sel = SLV_MODE_BISS;
    @(negedge clk);
    @(negedge clk);
    $display("mode_sel switched SSI->BiSS mid-frame");
    check("mode_abort", 64'(abort_cnt - a0), 64'd1);
    check("mode_busy", 64'(bus.busy), 64'd0);
    check("mode_slo", 64'(bus.slo_out), 64'd1);
    do_frame(SLV_MODE_BISS, 1'b0, 32'h0BADBEEF, 1'b1, 1'b1, cap);

    // asynchronous reset in the middle of a BiSS frame, away from any clk edge
    @(negedge clk);
    run_pulses(10, cap, oe_seen);
    check("arst_busy_before", 64'(bus.busy), 64'd1);
    check("arst_oe_before", 64'(bus.slo_oe), 64'd1);
    #2 resetn = 1'b0;
    #1;
    $display("async reset asserted mid-frame");
    check("arst_slo_oe", 64'(bus.slo_oe), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_slo_out", 64'(bus.slo_out), 64'd1);
    check("arst_done", 64'(bus.frame_done), 64'd0);
    check("arst_abort", 64'(bus.frame_abort), 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    do_frame(SLV_MODE_BISS, 1'b0, 32'h13579BDF, 1'b0, 1'b0, cap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
